// File: rtl/sync_req_fork.sv
// -----------------------------------------------------------------------------
// sync_req_fork
//
// Clocked initiator for a 4-phase return-to-zero handshake that is forked to
// OUT_NUM asynchronous branches. The block accepts one bundled-data word from
// synchronous logic and raises a single request to every branch. It holds the
// data stable until every branch has acknowledged, then completes the
// return-to-zero half of the cycle. Only after that does it accept another
// word. Each acknowledge is captured C-element style: once a branch has been
// seen high during the request phase, it stays counted.
//
// Ports
//   clk       in   clock
//   rst       in   synchronous, active-high reset
//   in_valid  in   sync-side word valid
//   in_ready  out  block can accept a word (high only in IDLE)
//   in_data   in   sync-side word [DATA_W]
//   req       out  request broadcast to all branches; registered, glitch-free
//   data_out  out  bundled data [DATA_W]; held for the whole handshake
//   ack       in   per-branch acknowledge [OUT_NUM]; asynchronous
//   done      out  one-cycle pulse when a handshake fully completes
//   err       out  sticky phase-timeout flag (cleared only by rst)
// -----------------------------------------------------------------------------
module sync_req_fork #(
   parameter int OUT_NUM     = 2,   // 1..32
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,   // 2..4
   parameter int TIMEOUT     = 0    // cycles per phase; 0 disables
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   output logic               req,
   output logic [DATA_W-1:0]  data_out,
   input  logic [OUT_NUM-1:0] ack,
   output logic               done,
   output logic               err
);

   localparam bit               TIMER_EN = (TIMEOUT > 0);
   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int               TERM     = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TERM);

   typedef enum logic [1:0] {IDLE, REQ_UP, REQ_DOWN, ERR} state_t;

   state_t             state, state_nxt;
   logic [OUT_NUM-1:0] sync_q [SYNC_STAGES];
   logic [OUT_NUM-1:0] ack_s;
   logic [OUT_NUM-1:0] flag, flag_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               req_nxt, done_nxt, err_nxt;
   logic [DATA_W-1:0]  data_nxt;
   logic               up_exit, down_exit, term_hit;

   // Acknowledge synchronizer. Every later decision looks only at ack_s.
   // NOTE: the synchronizer array holds real state, so it gets an explicit
   // reset. Otherwise a stale ack could leak into the first handshake after
   // reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= ack;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign ack_s = sync_q[SYNC_STAGES-1];

   // C-element completion: a branch counts once it has been seen high, even
   // if it has already dropped again.
   assign up_exit   = &(flag | ack_s);
   assign down_exit = ~|ack_s;
   assign term_hit  = TIMER_EN && (cnt == TERM_CNT);

   // in_ready comes straight from the state register, so it cannot glitch.
   assign in_ready  = (state == IDLE);

   // NOTE: every output of this block gets a default first. A path that
   // leaves a signal unassigned would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      req_nxt   = req;
      done_nxt  = 1'b0;
      err_nxt   = err;
      data_nxt  = data_out;
      flag_nxt  = flag;
      cnt_nxt   = cnt;

      unique case (state)
         IDLE: begin
            if (in_valid) begin
               data_nxt  = in_data;
               req_nxt   = 1'b1;
               flag_nxt  = '0;
               cnt_nxt   = '0;
               state_nxt = REQ_UP;
            end
         end

         REQ_UP: begin
            // If the exit and the terminal count coincide, the exit wins.
            if (up_exit) begin
               req_nxt   = 1'b0;
               flag_nxt  = '0;
               cnt_nxt   = '0;
               state_nxt = REQ_DOWN;
            end else if (term_hit) begin
               req_nxt   = 1'b0;
               err_nxt   = 1'b1;
               state_nxt = ERR;
            end else begin
               flag_nxt = flag | ack_s;
               cnt_nxt  = TIMER_EN ? cnt + CNT_W'(1) : '0;
            end
         end

         REQ_DOWN: begin
            if (down_exit) begin
               done_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else if (term_hit) begin
               err_nxt   = 1'b1;
               state_nxt = ERR;
            end else begin
               cnt_nxt = TIMER_EN ? cnt + CNT_W'(1) : '0;
            end
         end

         ERR: begin
            req_nxt = 1'b0;
            err_nxt = 1'b1;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments only, so every
   // flop samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         req      <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         data_out <= '0;
         flag     <= '0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         req      <= req_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
         data_out <= data_nxt;
         flag     <= flag_nxt;
         cnt      <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_sync_req_fork.sv
// -----------------------------------------------------------------------------
// tb_sync_req_fork
//
// Directed bench for sync_req_fork with OUT_NUM=3 and SYNC_STAGES=2. It uses
// two instances:
//   dut     TIMEOUT=0   basic handshake, sticky flags, back-to-back, reset
//   dut_to  TIMEOUT=10  timeout error, and an exit on the terminal count
// "Edge n" means the n-th rising clock edge after the edge that accepted the
// current word, which is edge 0. Inputs change 1 time unit after an edge, and
// outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_sync_req_fork;

   logic       clk = 1'b0;
   int         cyc;
   int         checks = 0;
   int         errors = 0;

   // Instance with the timeout disabled.
   logic       a_rst, a_in_valid, a_in_ready, a_req, a_done, a_err;
   logic [7:0] a_in_data, a_data_out;
   logic [2:0] a_ack_drv;
   logic [2:0] a_ack;
   logic       echo;

   // Instance with TIMEOUT=10.
   logic       t_rst, t_in_valid, t_in_ready, t_req, t_done, t_err;
   logic [7:0] t_in_data, t_data_out;
   logic [2:0] t_ack;

   // In echo mode every branch acknowledges instantly.
   assign a_ack = echo ? {3{a_req}} : a_ack_drv;

   always #5 clk = ~clk;

   sync_req_fork #(.OUT_NUM(3), .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(0)) dut (
      .clk      (clk),
      .rst      (a_rst),
      .in_valid (a_in_valid),
      .in_ready (a_in_ready),
      .in_data  (a_in_data),
      .req      (a_req),
      .data_out (a_data_out),
      .ack      (a_ack),
      .done     (a_done),
      .err      (a_err)
   );

   sync_req_fork #(.OUT_NUM(3), .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(10)) dut_to (
      .clk      (clk),
      .rst      (t_rst),
      .in_valid (t_in_valid),
      .in_ready (t_in_ready),
      .in_data  (t_in_data),
      .req      (t_req),
      .data_out (t_data_out),
      .ack      (t_ack),
      .done     (t_done),
      .err      (t_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // The next tick is edge 0.
   task automatic start();
      cyc = -1;
   endtask

   task automatic upto(input int e);
      while (cyc < e) tick();
   endtask

   initial begin
      a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_ack_drv = '0; echo = 1'b0;
      t_rst = 1'b1; t_in_valid = 1'b0; t_in_data = '0; t_ack = '0;
      cyc = 0;

      // ---------------- reset state ----------------
      tick(); tick();
      check("rst_req",      a_req,      0);
      check("rst_in_ready", a_in_ready, 1);
      check("rst_done",     a_done,     0);
      check("rst_err",      a_err,      0);
      check("rst_data",     a_data_out, 0);
      check("rst_to_ready", t_in_ready, 1);
      a_rst = 1'b0; t_rst = 1'b0;
      tick();

      // ---------------- basic handshake, acks at cycles 3/5/8 ----------------
      a_in_valid = 1'b1; a_in_data = 8'hA5;
      start(); upto(0);
      a_in_valid = 1'b0;
      check("t1_req_rise",  a_req,      1);
      check("t1_ready_lo",  a_in_ready, 0);
      check("t1_data",      a_data_out, 8'hA5);
      upto(3);  a_ack_drv[0] = 1'b1;
      upto(5);  a_ack_drv[1] = 1'b1;
      upto(8);  a_ack_drv[2] = 1'b1;
      upto(10);
      check("t1_req_e10",   a_req,      1);
      check("t1_data_e10",  a_data_out, 8'hA5);
      upto(11);
      check("t1_req_e11",   a_req,      0);
      check("t1_data_e11",  a_data_out, 8'hA5);
      upto(12); a_ack_drv = 3'b000;
      upto(14);
      check("t1_done_e14",  a_done,     0);
      check("t1_ready_e14", a_in_ready, 0);
      upto(15);
      check("t1_done_e15",  a_done,     1);
      check("t1_ready_e15", a_in_ready, 1);
      upto(16);
      check("t1_done_e16",  a_done,     0);

      // ------- sticky flag: branch 1 pulses 2-4, branches 0/2 rise at 6 -------
      // An ignored in_valid during REQ_DOWN is also covered here.
      a_in_valid = 1'b1; a_in_data = 8'h3C;
      start(); upto(0);
      a_in_valid = 1'b0;
      upto(2);  a_ack_drv[1] = 1'b1;
      upto(5);  a_ack_drv[1] = 1'b0;
      upto(6);  a_ack_drv[0] = 1'b1; a_ack_drv[2] = 1'b1;
      upto(8);
      check("t2_req_e8",    a_req,      1);
      upto(9);
      check("t2_req_e9",    a_req,      0);
      upto(10); a_ack_drv[0] = 1'b0;
      a_in_valid = 1'b1; a_in_data = 8'hFF;
      upto(11); a_in_valid = 1'b0;
      upto(12);
      check("t6_data_held", a_data_out, 8'h3C);
      check("t6_no_req",    a_req,      0);
      upto(14);
      check("t2_done_e14",  a_done,     0);
      check("t2_ready_e14", a_in_ready, 0);
      a_ack_drv[2] = 1'b0;
      upto(16);
      check("t2_done_e16",  a_done,     0);
      upto(17);
      check("t2_done_e17",  a_done,     1);
      upto(18);
      check("t6_no_extra",  a_req,      0);
      check("t6_data_e18",  a_data_out, 8'h3C);

      // ---------------- back-to-back with echoing acks ----------------
      echo = 1'b1;
      a_in_valid = 1'b1; a_in_data = 8'h01;
      start(); upto(0);
      a_in_data = 8'h02;
      check("t3_data_w1",   a_data_out, 8'h01);
      upto(3);
      check("t3_req_e3",    a_req,      0);
      upto(5);
      check("t3_data_e5",   a_data_out, 8'h01);
      check("t3_done_e5",   a_done,     0);
      upto(6);
      check("t3_done_e6",   a_done,     1);
      check("t3_ready_e6",  a_in_ready, 1);
      upto(7);
      a_in_valid = 1'b0;
      check("t3_data_w2",   a_data_out, 8'h02);
      check("t3_req_e7",    a_req,      1);
      check("t3_done_e7",   a_done,     0);
      upto(13);
      check("t3_done_e13",  a_done,     1);
      upto(14);
      check("t3_no_extra",  a_req,      0);
      check("t3_ready_e14", a_in_ready, 1);
      echo = 1'b0;
      tick();

      // ---------------- reset mid-handshake ----------------
      a_in_valid = 1'b1; a_in_data = 8'h77;
      start(); upto(0);
      a_in_valid = 1'b0;
      upto(1);  a_ack_drv = 3'b001;
      upto(4);  a_rst = 1'b1;
      upto(5);
      check("t5_req",       a_req,      0);
      check("t5_ready",     a_in_ready, 1);
      check("t5_done",      a_done,     0);
      check("t5_err",       a_err,      0);
      check("t5_data",      a_data_out, 0);
      a_rst = 1'b0; a_ack_drv = 3'b000;
      a_in_valid = 1'b1; a_in_data = 8'h5A;
      start(); upto(0);
      a_in_valid = 1'b0;
      check("t5_new_data",  a_data_out, 8'h5A);
      check("t5_new_req",   a_req,      1);
      upto(1);  a_ack_drv = 3'b111;
      upto(4);
      check("t5_req_fall",  a_req,      0);
      a_ack_drv = 3'b000;
      upto(7);
      check("t5_done",      a_done,     1);

      // ---------------- timeout: branch 2 stuck low ----------------
      t_in_valid = 1'b1; t_in_data = 8'h11;
      start(); upto(0);
      t_in_valid = 1'b0;
      check("t4_req_rise",  t_req,      1);
      upto(1);  t_ack = 3'b011;
      upto(9);
      check("t4_req_e9",    t_req,      1);
      check("t4_err_e9",    t_err,      0);
      upto(10);
      check("t4_err_e10",   t_err,      1);
      check("t4_req_e10",   t_req,      0);
      check("t4_ready_e10", t_in_ready, 0);
      t_in_valid = 1'b1; t_in_data = 8'hEE;
      upto(14);
      check("t4_err_stick", t_err,      1);
      check("t4_ready_stk", t_in_ready, 0);
      check("t4_req_stk",   t_req,      0);
      t_in_valid = 1'b0; t_rst = 1'b1; t_ack = 3'b000;
      upto(15);
      check("t4_err_clr",   t_err,      0);
      check("t4_ready_clr", t_in_ready, 1);
      t_rst = 1'b0;

      // ------- exit and terminal count on the same edge: the exit wins -------
      t_in_valid = 1'b1; t_in_data = 8'h22;
      start(); upto(0);
      t_in_valid = 1'b0;
      upto(7);  t_ack = 3'b111;
      upto(9);
      check("t4b_req_e9",   t_req,      1);
      upto(10);
      check("t4b_req_e10",  t_req,      0);
      check("t4b_err_e10",  t_err,      0);
      t_ack = 3'b000;
      upto(13);
      check("t4b_done",     t_done,     1);
      check("t4b_err_e13",  t_err,      0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_req_fork.md
Name: sync_req_fork

Overview:
- Clocked initiator for the 4-phase return-to-zero handshake whose acknowledge side is joined by the C-element completion tree.
- Accepts one bundled-data word from synchronous logic and broadcasts a single request to OUT_NUM asynchronous branches.
- Holds the data stable and completes the full req-up/ack-up/req-down/ack-down cycle against all branches before accepting the next word.
- Sits at the sync-to-async boundary, feeding async pipelines built from C-element stages.

Parameters:
OUT_NUM, 2, number of async branches forked; legal 1..32
DATA_W, 8, bundled data width
SYNC_STAGES, 2, flip-flop synchronizer depth per ack input; legal 2..4
TIMEOUT, 0, cycles allowed per handshake phase before error; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  sync-side word valid
in_ready  out  1  block can accept a word
in_data  in  DATA_W  sync-side word
req  out  1  request broadcast to all branches; registered, glitch-free
data_out  out  DATA_W  bundled data; stable whenever req=1 or acks are not all low
ack  in  OUT_NUM  per-branch acknowledge; asynchronous, synchronized internally
done  out  1  one-cycle pulse when a handshake fully completes
err  out  1  sticky timeout flag

Behaviour:
- Reset (sampled on clk edge with rst=1): state IDLE, req=0, done=0, err=0, in_ready=1, data_out=0, all synchronizer stages=0, capture flags=0, timeout counter=0. Reset overrides every other event in the same cycle.
- ack_s = ack after SYNC_STAGES flops. All decisions use ack_s only.
- States:
  - IDLE: in_ready=1. On in_valid=1, latch in_data into data_out, set req=1, go REQ_UP. req rises on the same edge that accepts the word.
  - REQ_UP: in_ready=0. flag[i] is set when ack_s[i]=1 and is sticky, giving C-element semantics. When (flag | ack_s) is all ones, req=0, clear flags, reset counter, go REQ_DOWN.
  - REQ_DOWN: in_ready=0, req=0, data_out held. When ack_s is all zeros, go IDLE and pulse done=1 for one cycle. in_ready=1 from that cycle.
  - ERR: req=0, in_ready=0, err=1. Exits only via rst.
- Latency: req falls SYNC_STAGES+1 edges after the last raw ack rise is captured. The block returns to IDLE SYNC_STAGES+1 edges after the last raw ack fall is captured.
- Minimum back-to-back period is 2*(SYNC_STAGES+1)+1 cycles with zero-delay branches.
- Timeout (TIMEOUT>0):
  - Counter increments each cycle in REQ_UP/REQ_DOWN and resets on each phase change.
  - When the counter reaches TIMEOUT-1 and the phase exit condition is still false, go ERR.
  - If the exit condition and the terminal count occur in the same cycle, the exit condition wins.
- Boundary cases:
  - ack[i] rising while in IDLE is ignored, but it blocks REQ_DOWN completion of a later handshake until it falls.
  - ack[i] dropping early in REQ_UP: the flag keeps it counted.
  - OUT_NUM=1 degenerates to a plain 4-phase initiator.
  - in_valid while in_ready=0 is ignored and the word is not latched.
  - Reset mid-handshake drops req on the next edge. The async side must be reset in the same cycle; this is an integration requirement.

Test Plan:
- OUT_NUM=3, SYNC_STAGES=2: accept in_data=0xA5 at edge 0; acks rise at cycles 3, 5, 8 -> req=1 from edge 0 to edge 11, data_out=0xA5 throughout. Acks all fall at cycle 12 -> done pulses at edge 15, in_ready=1.
- Branch 1 ack pulses high cycles 2-4 only; branches 0 and 2 rise at cycle 6 -> req still falls at edge 9 via the sticky flag. REQ_DOWN then waits for branches 0 and 2 to fall.
- Back-to-back: in_valid held with data 0x01, 0x02 and instantly echoing acks -> each word accepted exactly once. 0x02 is accepted in the cycle done pulses for 0x01; period is 7 cycles.
- TIMEOUT=10, branch 2 ack stuck low -> err=1 and req=0 at edge 10 after req rise; in_ready stays 0 until rst.
- rst asserted in REQ_UP at cycle 4 -> next edge: req=0, in_ready=1, done=0, err=0, data_out=0. A new word is accepted normally after release.
- in_valid=1 with in_data=0xFF while in REQ_DOWN -> not latched; data_out unchanged; no extra handshake.
